// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit bus CPU sequencer:
// opcodes, sequencer states, the control word, and per-opcode step counts.
package cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_MEM    = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC0  = 3'd3,
        ST_EXEC1  = 3'd4,
        ST_EXEC2  = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    typedef struct packed {
        logic pc_out;
        logic pc_add;
        logic pc_in;
        logic mar_in;
        logic ram_in;
        logic ram_out;
        logic ir_in;
        logic ir_out;
        logic a_in;
        logic a_out;
        logic b_in;
        logic b_out;
        logic alu_out;
        logic alu_sub;
        logic fl_in;
        logic output_in;
    } ctrl_t;

    // Number of execute steps an opcode occupies; every non-HLT opcode uses at least EXEC0.
    function automatic logic [1:0] op_steps(input logic [3:0] op);
        logic [1:0] steps;
        case (op)
            OP_LDA, OP_STA: steps = 2'd2;
            OP_ADD, OP_SUB: steps = 2'd3;
            default:        steps = 2'd1;
        endcase
        return steps;
    endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational micro-step decoder: maps state, latched opcode and flags
// to the raw (ungated) datapath control word.
module cpu_ctrl_decode
    import cpu_pkg::*;
(
    input  state_t     state,
    input  logic [3:0] opcode,
    input  logic       flag_c,
    input  logic       flag_z,
    output ctrl_t      ctrl
);

    // Decode the enables for the current micro-step; nothing is asserted by default.
    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.pc_out = 1'b1;
                ctrl.mar_in = 1'b1;
            end
            ST_MEM: begin
                ctrl.ram_out = 1'b1;
                ctrl.ir_in   = 1'b1;
                ctrl.pc_add  = 1'b1;
            end
            ST_EXEC0: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ctrl.ir_out = 1'b1;
                        ctrl.mar_in = 1'b1;
                    end
                    OP_LDI: begin
                        ctrl.ir_out = 1'b1;
                        ctrl.a_in   = 1'b1;
                    end
                    OP_JMP: begin
                        ctrl.ir_out = 1'b1;
                        ctrl.pc_in  = 1'b1;
                    end
                    OP_JC: begin
                        ctrl.ir_out = flag_c;
                        ctrl.pc_in  = flag_c;
                    end
                    OP_JZ: begin
                        ctrl.ir_out = flag_z;
                        ctrl.pc_in  = flag_z;
                    end
                    OP_OUT: begin
                        ctrl.a_out     = 1'b1;
                        ctrl.output_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_EXEC1: begin
                case (opcode)
                    OP_LDA: begin
                        ctrl.ram_out = 1'b1;
                        ctrl.a_in    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        ctrl.ram_out = 1'b1;
                        ctrl.b_in    = 1'b1;
                    end
                    OP_STA: begin
                        ctrl.a_out  = 1'b1;
                        ctrl.ram_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_EXEC2: begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    ctrl.alu_out = 1'b1;
                    ctrl.a_in    = 1'b1;
                    ctrl.fl_in   = 1'b1;
                    ctrl.alu_sub = (opcode == OP_SUB);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute sequencer for the 8-bit bus CPU. Holds the state and
// latched opcode, and gates the decoded enables with step_en and rst_n.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int EXEC_STEPS = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step_en,
    input  logic [7:0] ir,
    input  logic       flag_c,
    input  logic       flag_z,
    output logic       pc_out,
    output logic       pc_add,
    output logic       pc_in,
    output logic       mar_in,
    output logic       ram_in,
    output logic       ram_out,
    output logic       ir_in,
    output logic       ir_out,
    output logic       a_in,
    output logic       a_out,
    output logic       b_in,
    output logic       b_out,
    output logic       alu_out,
    output logic       alu_sub,
    output logic       fl_in,
    output logic       output_in,
    output logic       halted,
    output logic [2:0] t_state
);

    state_t     state;
    state_t     state_next;
    logic [3:0] opcode;
    logic [3:0] opcode_next;
    logic [1:0] exec_idx;
    logic       exec_last;
    ctrl_t      ctrl_raw;
    ctrl_t      ctrl;

    cpu_ctrl_decode u_decode (
        .state  (state),
        .opcode (opcode),
        .flag_c (flag_c),
        .flag_z (flag_z),
        .ctrl   (ctrl_raw)
    );

    assign exec_idx  = 2'(state - ST_EXEC0);
    assign exec_last = (int'(exec_idx) + 1 >= int'(op_steps(opcode)))
                    || (int'(exec_idx) + 1 >= EXEC_STEPS);

    // Next-state and opcode-latch logic; everything holds while step_en is low.
    always_comb begin
        state_next  = state;
        opcode_next = opcode;
        if (step_en) begin
            case (state)
                ST_FETCH:  state_next = ST_MEM;
                ST_MEM:    state_next = ST_DECODE;
                ST_DECODE: begin
                    opcode_next = ir[7:4];
                    state_next  = (ir[7:4] == OP_HLT) ? ST_HALT : ST_EXEC0;
                end
                ST_EXEC0, ST_EXEC1, ST_EXEC2:
                    state_next = exec_last ? ST_FETCH : state_t'(state + 3'd1);
                ST_HALT:   state_next = ST_HALT;
                default:   state_next = ST_FETCH;
            endcase
        end
    end

    // State and opcode registers; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_FETCH;
            opcode <= OP_NOP;
        end else begin
            state  <= state_next;
            opcode <= opcode_next;
        end
    end

    assign ctrl = (step_en && rst_n) ? ctrl_raw : '0;

    assign pc_out    = ctrl.pc_out;
    assign pc_add    = ctrl.pc_add;
    assign pc_in     = ctrl.pc_in;
    assign mar_in    = ctrl.mar_in;
    assign ram_in    = ctrl.ram_in;
    assign ram_out   = ctrl.ram_out;
    assign ir_in     = ctrl.ir_in;
    assign ir_out    = ctrl.ir_out;
    assign a_in      = ctrl.a_in;
    assign a_out     = ctrl.a_out;
    assign b_in      = ctrl.b_in;
    assign b_out     = ctrl.b_out;
    assign alu_out   = ctrl.alu_out;
    assign alu_sub   = ctrl.alu_sub;
    assign fl_in     = ctrl.fl_in;
    assign output_in = ctrl.output_in;

    assign halted  = (state == ST_HALT);
    assign t_state = state;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: stimulus pushes hand-computed expected
// state/enables per cycle, a monitor pops and compares on the falling edge.
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       step_en = 1'b0;
    logic [7:0] ir = 8'h00;
    logic       flag_c = 1'b0;
    logic       flag_z = 1'b0;
    logic       pc_out, pc_add, pc_in, mar_in, ram_in, ram_out, ir_in, ir_out;
    logic       a_in, a_out, b_in, b_out, alu_out, alu_sub, fl_in, output_in;
    logic       halted;
    logic [2:0] t_state;

    localparam logic [15:0] E_PC_OUT  = 16'h8000;
    localparam logic [15:0] E_PC_ADD  = 16'h4000;
    localparam logic [15:0] E_PC_IN   = 16'h2000;
    localparam logic [15:0] E_MAR_IN  = 16'h1000;
    localparam logic [15:0] E_RAM_IN  = 16'h0800;
    localparam logic [15:0] E_RAM_OUT = 16'h0400;
    localparam logic [15:0] E_IR_IN   = 16'h0200;
    localparam logic [15:0] E_IR_OUT  = 16'h0100;
    localparam logic [15:0] E_A_IN    = 16'h0080;
    localparam logic [15:0] E_A_OUT   = 16'h0040;
    localparam logic [15:0] E_B_IN    = 16'h0020;
    localparam logic [15:0] E_ALU_OUT = 16'h0008;
    localparam logic [15:0] E_ALU_SUB = 16'h0004;
    localparam logic [15:0] E_FL_IN   = 16'h0002;
    localparam logic [15:0] E_OUT_IN  = 16'h0001;
    localparam logic [15:0] E_NONE    = 16'h0000;

    typedef struct {
        string      name;
        logic [2:0] t;
        logic [15:0] ctrl;
        logic       halt;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fails = 0;
    logic [15:0] act_ctrl;

    assign act_ctrl = {pc_out, pc_add, pc_in, mar_in, ram_in, ram_out, ir_in, ir_out,
                       a_in, a_out, b_in, b_out, alu_out, alu_sub, fl_in, output_in};

    cpu_sequencer #(.EXEC_STEPS(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .step_en   (step_en),
        .ir        (ir),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .pc_out    (pc_out),
        .pc_add    (pc_add),
        .pc_in     (pc_in),
        .mar_in    (mar_in),
        .ram_in    (ram_in),
        .ram_out   (ram_out),
        .ir_in     (ir_in),
        .ir_out    (ir_out),
        .a_in      (a_in),
        .a_out     (a_out),
        .b_in      (b_in),
        .b_out     (b_out),
        .alu_out   (alu_out),
        .alu_sub   (alu_sub),
        .fl_in     (fl_in),
        .output_in (output_in),
        .halted    (halted),
        .t_state   (t_state)
    );

    always #5 clk = ~clk;

    // Compare the DUT's current outputs against one expected entry.
    task automatic checkOutput(input exp_t e);
        n_checks++;
        if ({t_state, act_ctrl, halted} !== {e.t, e.ctrl, e.halt}) begin
            n_fails++;
            $display("[TB] FAIL %s: got t_state=%0d ctrl=%h halted=%b, expected t_state=%0d ctrl=%h halted=%b",
                     e.name, t_state, act_ctrl, halted, e.t, e.ctrl, e.halt);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge and queue its expected response.
    task automatic applyStimulus(input string name, input logic r, input logic en,
                                 input logic [7:0] iv, input logic fc, input logic fz,
                                 input logic [2:0] et, input logic [15:0] ec, input logic eh);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n   = r;
        step_en = en;
        ir      = iv;
        flag_c  = fc;
        flag_z  = fz;
        e.name = name;
        e.t    = et;
        e.ctrl = ec;
        e.halt = eh;
        sb_q.push_back(e);
    endtask

    // Fetch, memory and decode cycles common to every instruction.
    task automatic prologue(input string name, input logic [7:0] iv);
        applyStimulus({name, "_fetch"},  1'b1, 1'b1, iv, 1'b0, 1'b0, 3'd0, E_PC_OUT | E_MAR_IN, 1'b0);
        applyStimulus({name, "_mem"},    1'b1, 1'b1, iv, 1'b0, 1'b0, 3'd1, E_RAM_OUT | E_IR_IN | E_PC_ADD, 1'b0);
        applyStimulus({name, "_decode"}, 1'b1, 1'b1, iv, 1'b0, 1'b0, 3'd2, E_NONE, 1'b0);
    endtask

    // Monitor: compare queued expectations and check bus-driver exclusivity every cycle.
    always @(negedge clk) begin
        n_checks++;
        if ($countones({pc_out, ram_out, ir_out, a_out, b_out, alu_out}) > 1) begin
            n_fails++;
            $display("[TB] FAIL bus_exclusive: got drivers=%b, expected at most one high",
                     {pc_out, ram_out, ir_out, a_out, b_out, alu_out});
        end
        if (sb_q.size() > 0) checkOutput(sb_q.pop_front());
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t e;
        applyStimulus("reset0", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 3'd0, E_NONE, 1'b0);
        applyStimulus("reset1", 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 3'd0, E_NONE, 1'b0);

        prologue("nop", 8'h00);
        applyStimulus("nop_e0", 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 3'd3, E_NONE, 1'b0);

        prologue("add", 8'h2A);
        applyStimulus("add_e0", 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 3'd3, E_IR_OUT | E_MAR_IN, 1'b0);
        applyStimulus("add_e1", 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 3'd4, E_RAM_OUT | E_B_IN, 1'b0);
        applyStimulus("add_e2", 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 3'd5, E_ALU_OUT | E_A_IN | E_FL_IN, 1'b0);

        prologue("sub", 8'h3A);
        applyStimulus("sub_e0", 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 3'd3, E_IR_OUT | E_MAR_IN, 1'b0);
        applyStimulus("sub_e1", 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 3'd4, E_RAM_OUT | E_B_IN, 1'b0);
        applyStimulus("sub_e2", 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 3'd5,
                      E_ALU_OUT | E_A_IN | E_FL_IN | E_ALU_SUB, 1'b0);

        prologue("jc_taken", 8'h75);
        applyStimulus("jc_taken_e0", 1'b1, 1'b1, 8'h75, 1'b1, 1'b0, 3'd3, E_IR_OUT | E_PC_IN, 1'b0);

        prologue("jc_untaken", 8'h75);
        applyStimulus("jc_untaken_e0", 1'b1, 1'b1, 8'h75, 1'b0, 1'b1, 3'd3, E_NONE, 1'b0);

        prologue("jz_taken", 8'h85);
        applyStimulus("jz_taken_e0", 1'b1, 1'b1, 8'h85, 1'b0, 1'b1, 3'd3, E_IR_OUT | E_PC_IN, 1'b0);

        prologue("ldi", 8'h53);
        applyStimulus("ldi_e0", 1'b1, 1'b1, 8'h53, 1'b0, 1'b0, 3'd3, E_IR_OUT | E_A_IN, 1'b0);

        prologue("jmp", 8'h64);
        applyStimulus("jmp_e0", 1'b1, 1'b1, 8'h64, 1'b0, 1'b0, 3'd3, E_IR_OUT | E_PC_IN, 1'b0);

        prologue("out", 8'hE0);
        applyStimulus("out_e0", 1'b1, 1'b1, 8'hE0, 1'b0, 1'b0, 3'd3, E_A_OUT | E_OUT_IN, 1'b0);

        prologue("unused", 8'hC7);
        applyStimulus("unused_e0", 1'b1, 1'b1, 8'hC7, 1'b1, 1'b1, 3'd3, E_NONE, 1'b0);

        prologue("lda", 8'h1B);
        applyStimulus("lda_e0",     1'b1, 1'b1, 8'h1B, 1'b0, 1'b0, 3'd3, E_IR_OUT | E_MAR_IN, 1'b0);
        applyStimulus("lda_stall0", 1'b1, 1'b0, 8'h1B, 1'b0, 1'b0, 3'd4, E_NONE, 1'b0);
        applyStimulus("lda_stall1", 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0, 3'd4, E_NONE, 1'b0);
        applyStimulus("lda_e1",     1'b1, 1'b1, 8'hF0, 1'b0, 1'b0, 3'd4, E_RAM_OUT | E_A_IN, 1'b0);

        prologue("sta", 8'h4C);
        applyStimulus("sta_e0", 1'b1, 1'b1, 8'h4C, 1'b0, 1'b0, 3'd3, E_IR_OUT | E_MAR_IN, 1'b0);
        applyStimulus("sta_e1", 1'b1, 1'b1, 8'h4C, 1'b0, 1'b0, 3'd4, E_A_OUT | E_RAM_IN, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        e.name = "sta_async_abort";
        e.t    = 3'd0;
        e.ctrl = E_NONE;
        e.halt = 1'b0;
        checkOutput(e);
        applyStimulus("sta_reset_hold", 1'b0, 1'b1, 8'h4C, 1'b0, 1'b0, 3'd0, E_NONE, 1'b0);

        prologue("hlt", 8'hF0);
        for (int i = 0; i < 22; i++)
            applyStimulus("halt_hold", 1'b1, 1'b1, 8'h00, i[0], i[1], 3'd6, E_NONE, 1'b1);
        applyStimulus("halt_stepoff", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd6, E_NONE, 1'b1);
        applyStimulus("halt_reset", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 3'd0, E_NONE, 1'b0);
        applyStimulus("post_halt_fetch", 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 3'd0, E_PC_OUT | E_MAR_IN, 1'b0);
        applyStimulus("post_halt_mem",   1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 3'd1, E_RAM_OUT | E_IR_IN | E_PC_ADD, 1'b0);

        @(negedge clk);
        #1;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fails++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Control sequencer for the 8-bit bus-based CPU. Steps fetch/decode/execute micro-states and drives every bus-driver and register-load enable (pc, mar, ram, ir, a, b, alu, output) so exactly one source drives the bus per cycle. Instructions are 8 bits: opcode in [7:4], operand/address nibble in [3:0] (16-byte RAM). Sits beside the datapath. Datapath registers capture on the `clk` edge that ends a cycle in which their load enable is high.

## Interface
Parameters:
- EXEC_STEPS, 3, maximum execute micro-steps per instruction (fixed ISA; not to be changed).

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- step_en  in  1  advance enable; 0 freezes sequencer and forces all control outputs to 0
- ir  in  8  instruction register contents
- flag_c, flag_z  in  1 each  carry/zero flags from flag register
- pc_out, pc_add, pc_in, mar_in, ram_in, ram_out, ir_in, ir_out, a_in, a_out, b_in, b_out, alu_out, alu_sub, fl_in, output_in  out  1 each  datapath enables (ir_out drives {4'h0, ir[3:0]} onto bus)
- halted  out  1  high in HALT state
- t_state  out  3  current state encoding, for debug/LEDs

## Operation
- States: FETCH(0), MEM(1), DECODE(2), EXEC0(3), EXEC1(4), EXEC2(5), HALT(6).
- FETCH: pc_out, mar_in. MEM: ram_out, ir_in, pc_add. DECODE: no enables; latch ir[7:4] into internal opcode register.
- EXEC steps by opcode (latched opcode only):
  - 0x0 NOP: none.
  - 0x1 LDA: E0 ir_out+mar_in; E1 ram_out+a_in.
  - 0x2 ADD: E0 ir_out+mar_in; E1 ram_out+b_in; E2 alu_out+a_in+fl_in.
  - 0x3 SUB: as ADD, plus alu_sub in E2.
  - 0x4 STA: E0 ir_out+mar_in; E1 a_out+ram_in.
  - 0x5 LDI: E0 ir_out+a_in.
  - 0x6 JMP: E0 ir_out+pc_in.
  - 0x7 JC / 0x8 JZ: E0 ir_out+pc_in only if flag_c / flag_z is 1 in EXEC0; otherwise no enables.
  - 0xE OUT: E0 a_out+output_in.
  - 0xF HLT: DECODE transitions to HALT, no EXEC.
  - 0x9–0xD: execute as NOP.
- Transitions: FETCH→MEM→DECODE→EXEC0 (HLT→HALT). After an opcode's last step, go to FETCH. Zero-step opcodes (NOP, unused, untaken-or-taken both 1-step for JC/JZ) still spend EXEC0: NOP/unused use EXEC0 as empty step. HALT is sticky; only rst_n exits.
- At most one bus driver (pc_out, ram_out, ir_out, a_out, b_out, alu_out) high in any cycle.

## Timing
- Outputs are combinational decode of state register, latched opcode, and flags, ANDed with step_en and rst_n.
- Reset (rst_n=0): state=FETCH, opcode=0, all control outputs 0, halted=0, t_state=0. First enabled cycle after release is FETCH.
- step_en=0: state and opcode hold, all enables 0, halted and t_state still reflect state.
- Instruction length in enabled cycles: NOP/LDI/JMP/JC/JZ/OUT/unused 4, LDA/STA 5, ADD/SUB 6, HLT 3 then halt.
- Flags are sampled combinationally in EXEC0 only. A change during other states has no effect.
- ir is read only in DECODE. Later ir changes are ignored for that instruction.
- Reset asserted mid-instruction aborts immediately. No partial step completes after the reset edge.

## Structure
- Shared package cpu_pkg: opcode localparams (OP_NOP…OP_HLT), state enum type, packed control-word struct of the 16 enables.
- One sub-module: cpu_ctrl_decode (purely combinational: state, opcode, flags → control word). cpu_sequencer holds state/opcode registers and gating.

## Test plan
- Reset release, step_en=1, ir=8'h00: t_state 0,1,2,3,0. FETCH shows pc_out=mar_in=1. MEM shows ram_out=ir_in=pc_add=1. No enables in DECODE/EXEC0.
- ir=8'h2A (ADD 0xA): EXEC0 ir_out+mar_in, EXEC1 ram_out+b_in, EXEC2 alu_out+a_in+fl_in, alu_sub=0. ir=8'h3A gives the same sequence with alu_sub=1 in EXEC2. Both take 6 cycles.
- ir=8'h75, flag_c=1: pc_in=ir_out=1 in EXEC0. With flag_c=0, EXEC0 has no enables. Both return to FETCH after 4 cycles.
- ir=8'hF0: FETCH, MEM, DECODE, then HALT. halted=1 and all enables 0 for 20+ cycles. Pulse rst_n low, then t_state=0 and halted=0.
- step_en toggled 1,0,0,1 during LDA: state holds and enables are 0 while low. No duplicate a_in across the stall. Total enabled cycles is 5.
- rst_n asserted asynchronously mid-EXEC1 of STA: ram_in drops immediately, t_state=0. Every cycle checks that at most one bus driver is high.
